// File: rtl/fp32_mult_issue_if.sv
// Operand and result streams of the fp32 multiplier issue block.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. The source holds its payload steady while valid=1 and ready=0.
// in_ready never depends on in_valid. out_valid never depends on out_ready.
interface fp32_mult_issue_if;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_a, in_b, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_a, in_b, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/fp32_mult_issue.sv
// Issue/collect sequencer that sits in front of a fixed-latency, non-stallable
// fp32 multiplier. The multiplier carries no valid bit, so a valid shift
// register tracks in-flight operations. Products land in a first-word-fall-
// through FIFO. Admission is credit based: at most FIFO_DEPTH operations may
// be outstanding (in flight + queued). Because of this, a result always has a
// free slot when it emerges, even while downstream stalls.
module fp32_mult_issue #(
  parameter int  MUL_LAT    = 4,
  parameter int  FIFO_DEPTH = 8,
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  fp32_mult_issue_if.slave io,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic [31:0]      mul_result,
  output logic [CW-1:0]    pending_cnt,
  output logic             busy,
  output logic             err_ovf
);

  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic               fire;
  logic               pop;
  logic               wr_en;
  logic               fifo_full;
  logic               do_wr;

  logic [MUL_LAT-1:0] vsr_q, vsr_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0]      pend_q, pend_d;
  logic               err_q, err_d;
  logic [31:0]        mem_q [FIFO_DEPTH];

  // Credit check only: in_ready looks at neither in_valid nor out_ready.
  assign io.in_ready = rstn & (pend_q < DEPTH_C);
  assign fire        = io.in_valid & io.in_ready;

  // Operands are zeroed when not issuing, so the multiplier sees quiet inputs.
  assign mul_a = fire ? io.in_a : 32'h0;
  assign mul_b = fire ? io.in_b : 32'h0;

  // FIFO head is presented combinationally (first-word fall-through).
  assign io.out_valid = (fifo_cnt_q != '0);
  assign io.out_data  = io.out_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign pop          = io.out_valid & io.out_ready;

  // The oldest valid bit lines up with the product on mul_result.
  assign wr_en     = vsr_q[MUL_LAT-1];
  assign fifo_full = (fifo_cnt_q == DEPTH_C);
  assign do_wr     = wr_en & (~fifo_full | pop);

  assign pending_cnt = pend_q;
  assign busy        = (pend_q != '0);
  assign err_ovf     = err_q;

  // Next-state: valid shift, FIFO pointers/count, credit counter, sticky error.
  always_comb begin
    vsr_d[0] = fire;
    for (int i = 1; i < MUL_LAT; i++) begin
      vsr_d[i] = vsr_q[i-1];
    end

    wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;

    fifo_cnt_d = fifo_cnt_q;
    if (do_wr && !pop) begin
      fifo_cnt_d = fifo_cnt_q + CW'(1);
    end else if (!do_wr && pop) begin
      fifo_cnt_d = fifo_cnt_q - CW'(1);
    end

    pend_d = pend_q;
    if (fire && !pop) begin
      pend_d = pend_q + CW'(1);
    end else if (!fire && pop) begin
      pend_d = pend_q - CW'(1);
    end

    // A product arriving at a full FIFO with no pop would be lost; flag it.
    err_d = err_q | (wr_en & fifo_full & ~pop);
  end

  // Control state registers; reset discards everything in flight and queued.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vsr_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      pend_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      vsr_q      <= vsr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
    end
  end

  // Result storage; contents are only meaningful where the count says so.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= mul_result;
    end
  end

endmodule

// File: tb/tb_fp32_mult_issue.sv
// Bench for fp32_mult_issue. A behavioural multiplier stand-in feeds
// mul_result. A queue model predicts the products, the credits and the
// point at which each product becomes visible.
module tb_fp32_mult_issue;
  localparam int MUL_LAT    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int CW         = $clog2(FIFO_DEPTH + 1);

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [31:0]   mul_a, mul_b, mul_result;
  logic [CW-1:0] pending_cnt;
  logic          busy, err_ovf;

  fp32_mult_issue_if io();

  fp32_mult_issue #(.MUL_LAT(MUL_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rstn(rstn), .io(io),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .pending_cnt(pending_cnt), .busy(busy), .err_ovf(err_ovf)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- fp32 arithmetic via double precision ----------------
  function automatic logic [63:0] f2d(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'h00) return {f[31], 63'b0};
    if (f[30:23] == 8'hFF) return {f[31], 11'h7FF, f[22:0], 29'b0};
    e = 11'(f[30:23]) + 11'd896;
    return {f[31], e, f[22:0], 29'b0};
  endfunction

  function automatic logic [31:0] d2f(input logic [63:0] d);
    int e;
    if (d[62:52] == 11'h7FF) return {d[63], 8'hFF, d[51:29]};
    e = int'(d[62:52]) - 896;
    if (e >= 255) return {d[63], 8'hFF, 23'b0};
    if (e <= 0) return {d[63], 31'b0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    real p;
    p = $bitstoreal(f2d(a)) * $bitstoreal(f2d(b));
    return d2f($realtobits(p));
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    e = 8'($urandom_range(100, 154));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  // ---------------- multiplier stand-in: MUL_LAT stages, no valid, no reset ----
  logic [31:0] mpipe [MUL_LAT];
  always @(posedge clk) begin
    mpipe[0] <= fp_mul(mul_a, mul_b);
    for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_result = mpipe[MUL_LAT-1];

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] exp_q[$];   // accepted, not yet popped products, oldest first
  int          vis_q[$];   // cycle number from which each product is visible
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;

  function automatic bit model_ov();
    return (exp_q.size() > 0) && (cyc >= vis_q[0]);
  endfunction

  function automatic bit model_rdy();
    return rstn && (exp_q.size() < FIFO_DEPTH);
  endfunction

  // Updates the model from the current inputs, then steps one clock edge.
  task automatic advance();
    bit f, p;
    f = model_rdy() && io.in_valid;
    p = rstn && io.out_ready && model_ov();
    if (!rstn) begin
      exp_q.delete();
      vis_q.delete();
    end else begin
      if (p) begin
        void'(exp_q.pop_front());
        void'(vis_q.pop_front());
      end
      if (f) begin
        exp_q.push_back(fp_mul(io.in_a, io.in_b));
        vis_q.push_back(cyc + 1 + MUL_LAT);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    io.in_valid = 1'b1; io.in_a = 32'h3F800000; io.in_b = 32'h40000000;
    io.out_ready = 1'b1;
    advance(); advance();
    #1;
    n_total++;
    if (io.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", io.in_ready); else n_pass++;
    n_total++;
    if (mul_a !== 32'h0 || mul_b !== 32'h0)
      $display("FAIL reset_mul_ops: got %h/%h want 0/0", mul_a, mul_b); else n_pass++;
    rstn = 1'b1; io.in_valid = 1'b0;
    #1;
    n_total++;
    if (io.in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b want 1", io.in_ready); else n_pass++;
    n_total++;
    if (io.out_valid !== 1'b0 || io.out_data !== 32'h0)
      $display("FAIL post_reset_out: got v=%b d=%h want v=0 d=0", io.out_valid, io.out_data); else n_pass++;
    n_total++;
    if (busy !== 1'b0 || pending_cnt !== '0 || err_ovf !== 1'b0)
      $display("FAIL post_reset_status: got busy=%b pend=%0d err=%b want 0/0/0", busy, pending_cnt, err_ovf);
    else n_pass++;
  endtask

  task automatic test_single_op();
    int lat;
    io.in_a = 32'h40000000; io.in_b = 32'h40400000; io.in_valid = 1'b1; io.out_ready = 1'b1;
    #1;
    n_total++;
    if (mul_a !== 32'h40000000 || mul_b !== 32'h40400000)
      $display("FAIL single_mul_ops: got %h/%h want 40000000/40400000", mul_a, mul_b); else n_pass++;
    advance();
    io.in_valid = 1'b0;
    n_total++;
    if (pending_cnt !== CW'(1) || busy !== 1'b1)
      $display("FAIL single_pending_1: got pend=%0d busy=%b want 1/1", pending_cnt, busy); else n_pass++;
    lat = 0;
    while (!io.out_valid && lat < 20) begin advance(); lat++; end
    n_total++;
    if (lat !== MUL_LAT) $display("FAIL single_latency: got %0d edges want %0d", lat, MUL_LAT); else n_pass++;
    n_total++;
    if (io.out_data !== 32'h40C00000) $display("FAIL single_product: got %h want 40c00000", io.out_data); else n_pass++;
    n_total++;
    if (pending_cnt !== CW'(1)) $display("FAIL single_pending_pre_pop: got %0d want 1", pending_cnt); else n_pass++;
    advance();
    n_total++;
    if (pending_cnt !== '0 || busy !== 1'b0 || io.out_valid !== 1'b0)
      $display("FAIL single_after_pop: got pend=%0d busy=%b v=%b want 0/0/0", pending_cnt, busy, io.out_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] pa [10];
    logic [31:0] pb [10];
    int idx, dut_fires, k;
    for (int i = 0; i < 10; i++) begin pa[i] = rand_fp(); pb[i] = rand_fp(); end
    idx = 0; dut_fires = 0;
    io.out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      io.in_valid = (idx < 10);
      io.in_a = (idx < 10) ? pa[idx] : 32'h0;
      io.in_b = (idx < 10) ? pb[idx] : 32'h0;
      #1;
      n_total++;
      if (io.in_ready !== model_rdy()) $display("FAIL bp_fill_in_ready: got %b want %b", io.in_ready, model_rdy()); else n_pass++;
      if (io.in_valid && io.in_ready) begin dut_fires++; idx++; end
      advance();
    end
    n_total++;
    if (dut_fires !== FIFO_DEPTH) $display("FAIL bp_fire_count: got %0d want %0d", dut_fires, FIFO_DEPTH); else n_pass++;
    n_total++;
    if (io.in_ready !== 1'b0 || pending_cnt !== CW'(FIFO_DEPTH))
      $display("FAIL bp_full: got rdy=%b pend=%0d want 0/%0d", io.in_ready, pending_cnt, FIFO_DEPTH); else n_pass++;
    io.out_ready = 1'b1;
    k = 0;
    while ((idx < 10 || exp_q.size() > 0) && k < 80) begin
      io.in_valid = (idx < 10);
      io.in_a = (idx < 10) ? pa[idx] : 32'h0;
      io.in_b = (idx < 10) ? pb[idx] : 32'h0;
      #1;
      n_total++;
      if (io.out_valid !== model_ov()) $display("FAIL bp_drain_valid: got %b want %b", io.out_valid, model_ov()); else n_pass++;
      if (model_ov()) begin
        n_total++;
        if (io.out_data !== exp_q[0]) $display("FAIL bp_drain_data: got %h want %h", io.out_data, exp_q[0]); else n_pass++;
      end
      if (io.in_valid && io.in_ready) idx++;
      advance();
      k++;
    end
    io.in_valid = 1'b0;
    n_total++;
    if (k >= 80) $display("FAIL bp_drain_timeout: got %0d cycles want <80", k); else n_pass++;
    n_total++;
    if (err_ovf !== 1'b0 || pending_cnt !== '0)
      $display("FAIL bp_end_state: got err=%b pend=%0d want 0/0", err_ovf, pending_cnt); else n_pass++;
  endtask

  task automatic test_fire_pop_full();
    int k;
    bit df, dp;
    io.out_ready = 1'b0;
    for (int c = 0; c < 40 && exp_q.size() < FIFO_DEPTH; c++) begin
      io.in_valid = 1'b1; io.in_a = rand_fp(); io.in_b = rand_fp();
      advance();
    end
    io.in_valid = 1'b0;
    repeat (MUL_LAT + 2) advance();
    // Full: offering a pop must not open in_ready in the same cycle.
    io.out_ready = 1'b1; io.in_valid = 1'b1; io.in_a = rand_fp(); io.in_b = rand_fp();
    #1;
    n_total++;
    if (io.in_ready !== 1'b0 || pending_cnt !== CW'(FIFO_DEPTH) || io.out_valid !== 1'b1)
      $display("FAIL full_state: got rdy=%b pend=%0d v=%b want 0/%0d/1", io.in_ready, pending_cnt, io.out_valid, FIFO_DEPTH);
    else n_pass++;
    n_total++;
    if (io.out_data !== exp_q[0]) $display("FAIL full_head: got %h want %h", io.out_data, exp_q[0]); else n_pass++;
    advance();
    #1;
    df = io.in_valid && io.in_ready;
    dp = io.out_valid && io.out_ready;
    n_total++;
    if (!(df && dp)) $display("FAIL fire_pop_same_cycle: got fire=%b pop=%b want 1/1", df, dp); else n_pass++;
    advance();
    n_total++;
    if (pending_cnt !== CW'(FIFO_DEPTH - 1))
      $display("FAIL fire_pop_pending: got %0d want %0d", pending_cnt, FIFO_DEPTH - 1); else n_pass++;
    io.in_valid = 1'b0;
    k = 0;
    while (exp_q.size() > 0 && k < 40) begin
      n_total++;
      if (io.out_valid !== model_ov()) $display("FAIL fp_drain_valid: got %b want %b", io.out_valid, model_ov()); else n_pass++;
      if (model_ov()) begin
        n_total++;
        if (io.out_data !== exp_q[0]) $display("FAIL fp_drain_data: got %h want %h", io.out_data, exp_q[0]); else n_pass++;
      end
      advance();
      k++;
    end
    n_total++;
    if (pending_cnt !== '0 || err_ovf !== 1'b0)
      $display("FAIL fp_end_state: got pend=%0d err=%b want 0/0", pending_cnt, err_ovf); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int idx, pops, first_pop, last_pop, peak, k;
    idx = 0; pops = 0; first_pop = -1; last_pop = -1; peak = 0; k = 0;
    io.out_ready = 1'b1;
    while ((idx < 32 || exp_q.size() > 0) && k < 32 + MUL_LAT + 20) begin
      io.in_valid = (idx < 32);
      io.in_a = rand_fp(); io.in_b = rand_fp();
      #1;
      if (idx < 32) begin
        n_total++;
        if (io.in_ready !== 1'b1) $display("FAIL stream_in_ready: got %b want 1 at op %0d", io.in_ready, idx); else n_pass++;
        n_total++;
        if (mul_a !== io.in_a || mul_b !== io.in_b)
          $display("FAIL stream_mul_ops: got %h/%h want %h/%h", mul_a, mul_b, io.in_a, io.in_b); else n_pass++;
      end
      n_total++;
      if (io.out_valid !== model_ov()) $display("FAIL stream_valid: got %b want %b", io.out_valid, model_ov()); else n_pass++;
      if (model_ov()) begin
        n_total++;
        if (io.out_data !== exp_q[0]) $display("FAIL stream_data: got %h want %h", io.out_data, exp_q[0]); else n_pass++;
      end
      if (io.out_valid && io.out_ready) begin
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        pops++;
      end
      if (int'(pending_cnt) > peak) peak = int'(pending_cnt);
      if (io.in_valid && io.in_ready) idx++;
      advance();
      k++;
    end
    io.in_valid = 1'b0;
    n_total++;
    if (pops !== 32 || last_pop - first_pop !== 31)
      $display("FAIL stream_contiguous: got %0d pops over %0d cycles want 32 over 32", pops, last_pop - first_pop + 1);
    else n_pass++;
    n_total++;
    if (peak !== MUL_LAT + 1) $display("FAIL stream_peak_pending: got %0d want %0d", peak, MUL_LAT + 1); else n_pass++;
  endtask

  task automatic test_special_values();
    logic [31:0] got [2];
    int n, k;
    io.out_ready = 1'b1;
    io.in_valid = 1'b1; io.in_a = 32'h7F800000; io.in_b = 32'h3F800000;
    advance();
    io.in_a = 32'h80000000; io.in_b = 32'h3F800000;
    advance();
    io.in_valid = 1'b0;
    n = 0; k = 0;
    while (n < 2 && k < 20) begin
      if (io.out_valid) begin got[n] = io.out_data; n++; end
      advance();
      k++;
    end
    n_total++;
    if (n !== 2) $display("FAIL special_count: got %0d want 2", n); else n_pass++;
    n_total++;
    if (got[0] !== 32'h7F800000) $display("FAIL special_inf: got %h want 7f800000", got[0]); else n_pass++;
    n_total++;
    if (got[1] !== 32'h80000000) $display("FAIL special_neg_zero: got %h want 80000000", got[1]); else n_pass++;
  endtask

  task automatic test_random();
    int k;
    for (int c = 0; c < 300; c++) begin
      io.in_valid = ($urandom_range(0, 3) != 0);
      io.out_ready = ($urandom_range(0, 1) != 0);
      io.in_a = rand_fp(); io.in_b = rand_fp();
      #1;
      n_total++;
      if (io.in_ready !== model_rdy()) $display("FAIL rand_in_ready: got %b want %b", io.in_ready, model_rdy()); else n_pass++;
      n_total++;
      if (int'(pending_cnt) !== exp_q.size()) $display("FAIL rand_pending: got %0d want %0d", pending_cnt, exp_q.size()); else n_pass++;
      n_total++;
      if (io.out_valid !== model_ov()) $display("FAIL rand_valid: got %b want %b", io.out_valid, model_ov()); else n_pass++;
      if (model_ov()) begin
        n_total++;
        if (io.out_data !== exp_q[0]) $display("FAIL rand_data: got %h want %h", io.out_data, exp_q[0]); else n_pass++;
      end
      advance();
    end
    io.in_valid = 1'b0; io.out_ready = 1'b1;
    k = 0;
    while (exp_q.size() > 0 && k < 40) begin
      n_total++;
      if (model_ov() && io.out_data !== exp_q[0]) $display("FAIL rand_drain_data: got %h want %h", io.out_data, exp_q[0]); else n_pass++;
      advance();
      k++;
    end
    n_total++;
    if (err_ovf !== 1'b0 || pending_cnt !== '0) $display("FAIL rand_end_state: got err=%b pend=%0d want 0/0", err_ovf, pending_cnt); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    int k;
    io.out_ready = 1'b0;
    io.in_valid = 1'b1;
    repeat (3) begin io.in_a = rand_fp(); io.in_b = rand_fp(); advance(); end
    io.in_valid = 1'b0;
    advance(); advance();
    rstn = 1'b0;
    io.in_valid = 1'b1; io.in_a = rand_fp(); io.in_b = rand_fp();
    #1;
    n_total++;
    if (mul_a !== 32'h0 || mul_b !== 32'h0 || io.in_ready !== 1'b0)
      $display("FAIL midreset_ops: got %h/%h rdy=%b want 0/0/0", mul_a, mul_b, io.in_ready); else n_pass++;
    advance();
    rstn = 1'b1; io.in_valid = 1'b0; io.out_ready = 1'b1;
    for (int c = 0; c < MUL_LAT + 2; c++) begin
      n_total++;
      if (io.out_valid !== 1'b0) $display("FAIL midreset_no_output: got %b want 0 at cycle %0d", io.out_valid, c); else n_pass++;
      advance();
    end
    n_total++;
    if (pending_cnt !== '0 || err_ovf !== 1'b0 || busy !== 1'b0)
      $display("FAIL midreset_status: got pend=%0d err=%b busy=%b want 0/0/0", pending_cnt, err_ovf, busy); else n_pass++;
    io.in_valid = 1'b1; io.in_a = 32'h40400000; io.in_b = 32'h3F000000;
    advance();
    io.in_valid = 1'b0;
    k = 0;
    while (!io.out_valid && k < 20) begin advance(); k++; end
    n_total++;
    if (io.out_valid !== 1'b1 || io.out_data !== 32'h3FC00000)
      $display("FAIL midreset_first_result: got v=%b d=%h want 1/3fc00000", io.out_valid, io.out_data); else n_pass++;
    advance();
    n_total++;
    if (io.out_valid !== 1'b0 || pending_cnt !== '0)
      $display("FAIL midreset_drained: got v=%b pend=%0d want 0/0", io.out_valid, pending_cnt); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    io.in_valid = 1'b0; io.in_a = 32'h0; io.in_b = 32'h0; io.out_ready = 1'b0;
    test_reset();
    test_single_op();
    test_backpressure();
    test_fire_pop_full();
    test_back_to_back();
    test_special_values();
    test_random();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "time limit reached");
  end

endmodule
